ahb_slave_arbiter: RTL and testbench

- Per-slave arbiter in the multi-layer AHB interconnect.
- Sits directly downstream of each master's address decoder. Collects hreq bit k from every master's decoder for slave k and grants the slave's address phase to one master, round-robin.
- Holds the grant for the length of a burst.
- Tracks the data-phase owner so the interconnect can steer write data and the slave response.

---
 rtl/ahb_slave_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_ahb_slave_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_arbiter.sv
// Per-slave AHB arbiter: round-robin address-phase grant, burst hold, data-phase owner tracking.
// Define AHB_ARB_LOCK_EN to add the hmastlock input and locked-ownership behaviour.
module ahb_slave_arbiter #(
    parameter int MASTER_NUM = 4,
    parameter int MIDX_W     = $clog2(MASTER_NUM)
) (
    input  logic                    hclk,
    input  logic                    hreset_n,
    input  logic [MASTER_NUM-1:0]   hreq,
    input  logic [2*MASTER_NUM-1:0] htrans,
    input  logic [3*MASTER_NUM-1:0] hburst,
`ifdef AHB_ARB_LOCK_EN
    input  logic [MASTER_NUM-1:0]   hmastlock,
`endif
    input  logic                    hready,
    output logic [MASTER_NUM-1:0]   hgrant,
    output logic [MIDX_W-1:0]       haddr_sel,
    output logic [MIDX_W-1:0]       hdata_sel,
    output logic                    hdata_valid,
    output logic [1:0]              dbg_state
);

    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [2:0] BU_SINGLE = 3'd0;
    localparam logic [2:0] BU_INCR   = 3'd1;

    typedef enum logic [1:0] {
        IDLE_S  = 2'd0,
        OWN_S   = 2'd1,
        BURST_S = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [MASTER_NUM-1:0]   grant_q, grant_d;
    logic [MIDX_W-1:0]       addr_sel_q, addr_sel_d;
    logic [MIDX_W-1:0]       data_sel_q, data_sel_d;
    logic [MIDX_W-1:0]       ptr_q, ptr_d;
    logic                    data_valid_q, data_valid_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    incr_q, incr_d;

    logic [1:0]              own_trans;
    logic [2:0]              own_burst;
    logic                    owned;
    logic [3:0]              burst_load;
    logic [MIDX_W-1:0]       rr_idx;
    logic                    win_found;
    logic [MIDX_W-1:0]       win_idx, win_next;
    logic                    rearb;
    logic                    hold;

    assign owned = |grant_q;

    always_comb begin
        own_trans = 2'b00;
        own_burst = 3'd0;
        for (int m = 0; m < MASTER_NUM; m++) begin
            if (addr_sel_q == MIDX_W'(m)) begin
                own_trans = htrans[2*m +: 2];
                own_burst = hburst[3*m +: 3];
            end
        end
    end

    // Scan downward so the lowest offset from the pointer is the last (winning) assignment.
    always_comb begin
        rr_idx    = '0;
        win_found = 1'b0;
        win_idx   = '0;
        win_next  = '0;
        for (int i = MASTER_NUM - 1; i >= 0; i--) begin
            rr_idx = MIDX_W'((int'(ptr_q) + i) % MASTER_NUM);
            if (hreq[rr_idx]) begin
                win_found = 1'b1;
                win_idx   = rr_idx;
                win_next  = MIDX_W'((int'(ptr_q) + i + 1) % MASTER_NUM);
            end
        end
    end

    always_comb begin
        case (own_burst)
            3'd2, 3'd3: burst_load = 4'd3;
            3'd4, 3'd5: burst_load = 4'd7;
            3'd6, 3'd7: burst_load = 4'd15;
            default:    burst_load = 4'd0;
        endcase
    end

`ifdef AHB_ARB_LOCK_EN
    logic lock_q, lock_d, own_lock;

    always_comb begin
        own_lock = 1'b0;
        for (int m = 0; m < MASTER_NUM; m++) begin
            if (addr_sel_q == MIDX_W'(m)) own_lock = hmastlock[m];
        end
        hold   = owned && own_lock && (lock_q || own_trans == TR_NONSEQ);
        lock_d = hready ? hold : lock_q;
    end

    always_ff @(posedge hclk) begin
        if (!hreset_n) lock_q <= 1'b0;
        else           lock_q <= lock_d;
    end
`else
    assign hold = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        addr_sel_d   = addr_sel_q;
        data_sel_d   = data_sel_q;
        data_valid_d = data_valid_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        incr_d       = incr_q;
        rearb        = 1'b0;
        if (hready) begin
            data_sel_d   = addr_sel_q;
            data_valid_d = owned && own_trans[1];
            case (state_q)
                IDLE_S: rearb = 1'b1;
                OWN_S: begin
                    if (owned && own_trans == TR_NONSEQ && own_burst != BU_SINGLE) begin
                        state_d = BURST_S;
                        cnt_d   = burst_load;
                        incr_d  = (own_burst == BU_INCR);
                    end else begin
                        rearb = 1'b1;
                    end
                end
                BURST_S: begin
                    if (own_trans == TR_SEQ) begin
                        if (!incr_q) begin
                            if (cnt_q <= 4'd1) begin
                                cnt_d   = 4'd0;
                                state_d = OWN_S;
                                rearb   = 1'b1;
                            end else begin
                                cnt_d = cnt_q - 4'd1;
                            end
                        end
                    end else if (own_trans != TR_BUSY) begin
                        // IDLE or NONSEQ from the owner ends the burst early.
                        cnt_d   = 4'd0;
                        state_d = OWN_S;
                        rearb   = 1'b1;
                    end
                end
                default: state_d = IDLE_S;
            endcase
            if (rearb && !hold) begin
                if (win_found) begin
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    addr_sel_d       = win_idx;
                    ptr_d            = win_next;
                    state_d          = OWN_S;
                end else begin
                    grant_d = '0;
                    state_d = IDLE_S;
                end
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (!hreset_n) begin
            state_q      <= IDLE_S;
            grant_q      <= '0;
            addr_sel_q   <= '0;
            data_sel_q   <= '0;
            data_valid_q <= 1'b0;
            ptr_q        <= '0;
            cnt_q        <= 4'd0;
            incr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            addr_sel_q   <= addr_sel_d;
            data_sel_q   <= data_sel_d;
            data_valid_q <= data_valid_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            incr_q       <= incr_d;
        end
    end

    assign hgrant      = grant_q;
    assign haddr_sel   = addr_sel_q;
    assign hdata_sel   = data_sel_q;
    assign hdata_valid = data_valid_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Bench for ahb_slave_arbiter: directed burst/lock scenarios then randomized traffic,
// all checked against a transaction-level ownership model.
module tb_ahb_slave_arbiter;

    localparam int N = 4;
    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [2:0] SINGLE = 3'd0, INCR = 3'd1, WRAP4 = 3'd2, INCR4 = 3'd3;
    localparam logic [2:0] WRAP8 = 3'd4;

    logic           hclk = 1'b0;
    logic           hreset_n;
    logic [N-1:0]   hreq;
    logic [2*N-1:0] htrans;
    logic [3*N-1:0] hburst;
`ifdef AHB_ARB_LOCK_EN
    logic [N-1:0]   hmastlock;
`endif
    logic           hready;
    logic [N-1:0]   hgrant;
    logic [1:0]     haddr_sel;
    logic [1:0]     hdata_sel;
    logic           hdata_valid;
    logic [1:0]     dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: who owns the slave, how many beats of its burst remain.
    int m_owner;
    int m_next;
    int m_asel;
    int m_dsel;
    bit m_dvalid;
    bit m_in_burst;
    bit m_undef;
    int m_left;
    bit m_locked;

    ahb_slave_arbiter #(.MASTER_NUM(N)) dut (
        .hclk        (hclk),
        .hreset_n    (hreset_n),
        .hreq        (hreq),
        .htrans      (htrans),
        .hburst      (hburst),
`ifdef AHB_ARB_LOCK_EN
        .hmastlock   (hmastlock),
`endif
        .hready      (hready),
        .hgrant      (hgrant),
        .haddr_sel   (haddr_sel),
        .hdata_sel   (hdata_sel),
        .hdata_valid (hdata_valid),
        .dbg_state   (dbg_state)
    );

    always #5 hclk = ~hclk;

    function automatic int burst_beats(input logic [2:0] b);
        case (b)
            3'd0:       return 1;
            3'd1:       return 0;
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            default:    return 16;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int o;
        int k;
        logic [1:0] t;
        logic [2:0] b;
        bit rel;
        bit hold;
        if (!hreset_n) begin
            m_owner = -1; m_next = 0; m_asel = 0; m_dsel = 0; m_dvalid = 0;
            m_in_burst = 0; m_undef = 0; m_left = 0; m_locked = 0;
            return;
        end
        if (!hready) return;
        o = m_owner;
        t = TR_IDLE;
        b = SINGLE;
        if (o >= 0) begin
            t = htrans[2*o +: 2];
            b = hburst[3*o +: 3];
        end
        m_dsel   = m_asel;
        m_dvalid = (o >= 0) && (t == TR_NONSEQ || t == TR_SEQ);
        rel = 1;
        if (o >= 0 && !m_in_burst && t == TR_NONSEQ && b != SINGLE) begin
            m_in_burst = 1;
            m_undef    = (burst_beats(b) == 0);
            m_left     = burst_beats(b) - 1;
            rel        = 0;
        end else if (m_in_burst) begin
            if (t == TR_BUSY) begin
                rel = 0;
            end else if (t == TR_SEQ && (m_undef || m_left > 1)) begin
                if (!m_undef) m_left--;
                rel = 0;
            end else begin
                m_in_burst = 0;
            end
        end
        hold = 0;
`ifdef AHB_ARB_LOCK_EN
        if (o >= 0) hold = hmastlock[o] && (m_locked || t == TR_NONSEQ);
`endif
        m_locked = hold;
        if (rel && !hold) begin
            m_owner = -1;
            for (int i = 0; i < N; i++) begin
                k = (m_next + i) % N;
                if (m_owner < 0 && hreq[k]) m_owner = k;
            end
            if (m_owner >= 0) begin
                m_asel = m_owner;
                m_next = (m_owner + 1) % N;
            end
        end
    endtask

    task automatic tick();
        logic [N-1:0] eg;
        model_edge();
        @(posedge hclk);
        #1;
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        chk("hgrant", 32'(hgrant), 32'(eg));
        if (m_owner >= 0) chk("haddr_sel", 32'(haddr_sel), 32'(m_asel));
        chk("hdata_sel", 32'(hdata_sel), 32'(m_dsel));
        chk("hdata_valid", 32'(hdata_valid), 32'(m_dvalid));
    endtask

    task automatic drive(input int m, input logic [1:0] t, input logic [2:0] b);
        htrans[2*m +: 2] = t;
        hburst[3*m +: 3] = b;
        hreq[m]          = (t != TR_IDLE);
    endtask

    task automatic idle_all();
        for (int m = 0; m < N; m++) drive(m, TR_IDLE, SINGLE);
`ifdef AHB_ARB_LOCK_EN
        hmastlock = '0;
`endif
    endtask

    initial begin
        logic [1:0] rt;
        int r;
        hreset_n = 1'b0;
        hready   = 1'b1;
        hreq     = '0;
        htrans   = '0;
        hburst   = '0;
        idle_all();

        // Reset with every master requesting, then round-robin hand-off after a SINGLE.
        for (int m = 0; m < N; m++) drive(m, TR_NONSEQ, SINGLE);
        tick();
        tick();
        chk("t1_reset_grant", 32'(hgrant), 32'h0);
        chk("t1_reset_dvalid", 32'(hdata_valid), 32'h0);
        chk("t1_reset_dsel", 32'(hdata_sel), 32'h0);
        hreset_n = 1'b1;
        tick();
        chk("t1_first_grant", 32'(hgrant), 32'b0001);
        tick();
        chk("t1_after_single", 32'(hgrant), 32'b0010);
        idle_all();
        tick();
        tick();

        // M1 INCR4 with M2 waiting.
        drive(1, TR_NONSEQ, INCR4);
        tick();
        chk("t2_grant_m1", 32'(hgrant), 32'b0010);
        drive(2, TR_NONSEQ, SINGLE);
        tick();
        chk("t2_beat_nonseq", 32'(hgrant), 32'b0010);
        drive(1, TR_SEQ, INCR4);
        tick();
        chk("t2_beat_seq1", 32'(hgrant), 32'b0010);
        tick();
        chk("t2_beat_seq2", 32'(hgrant), 32'b0010);
        tick();
        chk("t2_handoff_m2", 32'(hgrant), 32'b0100);
        idle_all();
        tick();
        tick();

        // M0 INCR4 with a BUSY and two wait states, M1 waiting.
        drive(0, TR_NONSEQ, INCR4);
        tick();
        chk("t3_grant_m0", 32'(hgrant), 32'b0001);
        drive(1, TR_NONSEQ, SINGLE);
        tick();
        chk("t3_dvalid_nonseq", 32'(hdata_valid), 32'h1);
        chk("t3_dsel_nonseq", 32'(hdata_sel), 32'h0);
        drive(0, TR_SEQ, INCR4);
        hready = 1'b0;
        tick();
        chk("t3_wait1_grant", 32'(hgrant), 32'b0001);
        hready = 1'b1;
        tick();
        drive(0, TR_BUSY, INCR4);
        tick();
        chk("t3_busy_grant", 32'(hgrant), 32'b0001);
        drive(0, TR_SEQ, INCR4);
        tick();
        chk("t3_seq2_grant", 32'(hgrant), 32'b0001);
        hready = 1'b0;
        tick();
        chk("t3_wait2_grant", 32'(hgrant), 32'b0001);
        hready = 1'b1;
        tick();
        chk("t3_handoff_m1", 32'(hgrant), 32'b0010);
        chk("t3_last_dvalid", 32'(hdata_valid), 32'h1);
        chk("t3_last_dsel", 32'(hdata_sel), 32'h0);
        idle_all();
        tick();
        tick();

        // M3 undefined-length INCR: six SEQ beats then IDLE, M0 waiting.
        drive(3, TR_NONSEQ, INCR);
        tick();
        chk("t4_grant_m3", 32'(hgrant), 32'b1000);
        drive(0, TR_NONSEQ, SINGLE);
        tick();
        drive(3, TR_SEQ, INCR);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t4_hold", 32'(hgrant), 32'b1000);
        end
        drive(3, TR_IDLE, INCR);
        tick();
        chk("t4_handoff_m0", 32'(hgrant), 32'b0001);
        idle_all();
        tick();
        tick();

        // M2 WRAP8 cut short by a NONSEQ after two SEQ beats, M3 waiting.
        drive(2, TR_NONSEQ, WRAP8);
        tick();
        drive(3, TR_NONSEQ, SINGLE);
        tick();
        drive(2, TR_SEQ, WRAP8);
        tick();
        tick();
        chk("t5_hold", 32'(hgrant), 32'b0100);
        drive(2, TR_NONSEQ, SINGLE);
        tick();
        chk("t5_early_term_m3", 32'(hgrant), 32'b1000);
        idle_all();
        tick();
        tick();

`ifdef AHB_ARB_LOCK_EN
        // M1 locked across two SINGLEs and an IDLE, M0 waiting.
        drive(1, TR_NONSEQ, SINGLE);
        hmastlock[1] = 1'b1;
        tick();
        chk("t6_grant_m1", 32'(hgrant), 32'b0010);
        drive(0, TR_NONSEQ, SINGLE);
        tick();
        tick();
        chk("t6_locked_single", 32'(hgrant), 32'b0010);
        drive(1, TR_IDLE, SINGLE);
        tick();
        chk("t6_locked_idle", 32'(hgrant), 32'b0010);
        hmastlock[1] = 1'b0;
        tick();
        chk("t6_unlock_m0", 32'(hgrant), 32'b0001);
        idle_all();
        tick();
        tick();
`endif

        // Randomized traffic, SEQ-biased so bursts run for a while.
        for (int c = 0; c < 1500; c++) begin
            hready   = ($urandom_range(0, 3) != 0);
            hreset_n = ($urandom_range(0, 199) != 0);
            for (int m = 0; m < N; m++) begin
                r = $urandom_range(0, 19);
                if (r < 3)       rt = TR_IDLE;
                else if (r < 5)  rt = TR_BUSY;
                else if (r < 10) rt = TR_NONSEQ;
                else             rt = TR_SEQ;
                drive(m, rt, 3'($urandom_range(0, 7)));
                if ($urandom_range(0, 7) == 0) hreq[m] = 1'b0;
`ifdef AHB_ARB_LOCK_EN
                hmastlock[m] = ($urandom_range(0, 5) == 0);
`endif
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
